// File: rtl/mandel_scan_scheduler_if.sv
// Pixel coordinate stream from the raster scheduler to the iteration engines.
// The scheduler drives the stream as master. The engines accept it as slave.
interface mandel_scan_scheduler_if #(
    parameter int MAX_X = 64,
    parameter int MAX_Y = 48
);
    localparam int PX_W = $clog2(MAX_X);
    localparam int PY_W = $clog2(MAX_Y);

    logic            out_valid;
    logic            out_ready;
    logic [PX_W-1:0] out_px;
    logic [PY_W-1:0] out_py;
    logic [31:0]     out_re;
    logic [31:0]     out_im;

    modport master (
        output out_valid, out_px, out_py, out_re, out_im,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_px, out_py, out_re, out_im,
        output out_ready
    );
endinterface

// File: rtl/mandel_scan_scheduler.sv
// Raster-scan controller: walks a MAX_X x MAX_Y frame and streams each pixel's Q8.24
// complex coordinate, which it builds incrementally from the origin/step registers.
module mandel_scan_scheduler #(
    parameter int FRAC_BITS = 24,
    parameter int MAX_X     = 64,
    parameter int MAX_Y     = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        frame_done,
    mandel_scan_scheduler_if.master out_if
);
    localparam int PX_W = $clog2(MAX_X);
    localparam int PY_W = $clog2(MAX_Y);

    if (FRAC_BITS < 0 || FRAC_BITS > 31) begin : g_bad_frac
        $error("FRAC_BITS must lie within a 32-bit coordinate");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     origin_x_q, origin_x_d, origin_y_q, origin_y_d;
    logic [31:0]     step_x_q, step_x_d, step_y_q, step_y_d;
    logic [PX_W-1:0] px_q, px_d;
    logic [PY_W-1:0] py_q, py_d;
    logic [31:0]     re_q, re_d, im_q, im_d;
    logic            valid_q, valid_d;
    logic            frame_done_q, frame_done_d;

    // Start samples the registers as they were before any write in the same cycle.
    always_comb begin
        state_d      = state_q;
        origin_x_d   = origin_x_q;
        origin_y_d   = origin_y_q;
        step_x_d     = step_x_q;
        step_y_d     = step_y_q;
        px_d         = px_q;
        py_d         = py_q;
        re_d         = re_q;
        im_d         = im_q;
        valid_d      = valid_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    case (cfg_addr)
                        2'd0:    origin_x_d = cfg_data;
                        2'd1:    origin_y_d = cfg_data;
                        2'd2:    step_x_d   = cfg_data;
                        default: step_y_d   = cfg_data;
                    endcase
                end
                if (start) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    px_d    = '0;
                    py_d    = '0;
                    re_d    = origin_x_q;
                    im_d    = origin_y_q;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (valid_q && out_if.out_ready) begin
                    if (px_q != PX_W'(MAX_X - 1)) begin
                        px_d = px_q + PX_W'(1);
                        re_d = re_q + step_x_q;
                    end else if (py_q != PY_W'(MAX_Y - 1)) begin
                        px_d = '0;
                        re_d = origin_x_q;
                        py_d = py_q + PY_W'(1);
                        im_d = im_q + step_y_q;
                    end else begin
                        // Final pixel: leave coordinates on the last pixel while idle.
                        state_d      = IDLE;
                        valid_d      = 1'b0;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            origin_x_q   <= '0;
            origin_y_q   <= '0;
            step_x_q     <= '0;
            step_y_q     <= '0;
            px_q         <= '0;
            py_q         <= '0;
            re_q         <= '0;
            im_q         <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            origin_x_q   <= origin_x_d;
            origin_y_q   <= origin_y_d;
            step_x_q     <= step_x_d;
            step_y_q     <= step_y_d;
            px_q         <= px_d;
            py_q         <= py_d;
            re_q         <= re_d;
            im_q         <= im_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy             = (state_q == RUN);
    assign frame_done       = frame_done_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_px    = px_q;
    assign out_if.out_py    = py_q;
    assign out_if.out_re    = re_q;
    assign out_if.out_im    = im_q;
endmodule
